// File: rtl/mdu_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_wb_if
// Brief    : MDU result buses in, writeback valid/ready handshake out.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_wb_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_op;
  logic [4:0]               in_rd;
  logic [TAG_W-1:0]         in_tag;
  logic [2*XLEN-1:0]        mul_ss;
  logic [2*XLEN-1:0]        mul_su;
  logic [2*XLEN-1:0]        mul_uu;
  logic [XLEN-1:0]          div_s;
  logic [XLEN-1:0]          div_u;
  logic [XLEN-1:0]          rem_s;
  logic [XLEN-1:0]          rem_u;
  logic [2*XLEN-1:0]        clmul;
  logic [2*XLEN-1:0]        clmulr;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_data;
  logic [4:0]               out_rd;
  logic [TAG_W-1:0]         out_tag;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   count;

  // MDU + writeback side
  modport master (
    output in_valid, in_op, in_rd, in_tag,
    output mul_ss, mul_su, mul_uu, div_s, div_u, rem_s, rem_u, clmul, clmulr,
    output out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_tag, out_illegal, count
  );

  // Buffer side
  modport slave (
    input  in_valid, in_op, in_rd, in_tag,
    input  mul_ss, mul_su, mul_uu, div_s, div_u, rem_s, rem_u, clmul, clmulr,
    input  out_ready,
    output in_ready, out_valid, out_data, out_rd, out_tag, out_illegal, count
  );
endinterface
`default_nettype wire

// File: rtl/mdu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_wb_buffer
// Brief    : Selects the architectural MDU result and queues it for writeback.
//            Optional same-cycle bypass when empty: define MDU_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_wb_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic flush,
  mdu_wb_if.slave   bus
);
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

  logic [XLEN-1:0]  w_sel;
  logic             w_ill;
  logic             w_in_ready;
  logic             w_nonempty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  logic [XLEN-1:0]  r_data [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic             r_ill  [DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;

  always_comb begin
    w_sel = '0;
    w_ill = 1'b0;
    case (bus.in_op)
      4'd0:    w_sel = bus.mul_ss[XLEN-1:0];
      4'd1:    w_sel = bus.mul_ss[2*XLEN-1:XLEN];
      4'd2:    w_sel = bus.mul_su[2*XLEN-1:XLEN];
      4'd3:    w_sel = bus.mul_uu[2*XLEN-1:XLEN];
      4'd4:    w_sel = bus.div_s;
      4'd5:    w_sel = bus.div_u;
      4'd6:    w_sel = bus.rem_s;
      4'd7:    w_sel = bus.rem_u;
      4'd8:    w_sel = bus.clmul[XLEN-1:0];
      4'd9:    w_sel = bus.clmul[2*XLEN-1:XLEN];
      4'd10:   w_sel = bus.clmulr[XLEN-1:0];
      default: w_ill = 1'b1;
    endcase
  end

  // Halves of the product buses that no op ever selects
  assign w_unused = ^{bus.mul_su[XLEN-1:0], bus.mul_uu[XLEN-1:0],
                      bus.clmulr[2*XLEN-1:XLEN]};

  assign w_nonempty = (r_count != '0);
  // Registered occupancy only: a same-cycle pop does not open a slot
  assign w_in_ready = (r_count < c_DEPTH_CNT);

`ifdef MDU_WB_BYPASS_EN
  assign w_bypass = !w_nonempty && bus.in_valid && bus.out_ready && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = bus.in_valid && w_in_ready && !flush && !w_bypass;
  assign w_pop  = w_nonempty && bus.out_ready && !flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_data[i] <= '0;
          r_rd[i]   <= '0;
          r_tag[i]  <= '0;
          r_ill[i]  <= 1'b0;
        end else if (w_push && (r_wptr == c_PW'(i))) begin
          r_data[i] <= w_sel;
          r_rd[i]   <= bus.in_rd;
          r_tag[i]  <= bus.in_tag;
          r_ill[i]  <= w_ill;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.out_data    = '0;
    bus.out_rd      = '0;
    bus.out_tag     = '0;
    bus.out_illegal = 1'b0;
    if (w_nonempty) begin
      bus.out_data    = r_data[r_rptr];
      bus.out_rd      = r_rd[r_rptr];
      bus.out_tag     = r_tag[r_rptr];
      bus.out_illegal = r_ill[r_rptr];
    end else if (w_bypass) begin
      bus.out_data    = w_sel;
      bus.out_rd      = bus.in_rd;
      bus.out_tag     = bus.in_tag;
      bus.out_illegal = w_ill;
    end
  end

  assign bus.out_valid = (w_nonempty && !flush) || w_bypass;
  assign bus.in_ready  = w_in_ready;
  assign bus.count     = r_count;

endmodule
`default_nettype wire
